tx_word_arbiter: RTL and testbench
==================================

Name: tx_word_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single 32-bit-word byte-serial transmit path among NREQ requesters, e.g. CPU dump, RAM readout and debug status.
- Sits between the requesters and the word transmitter, which sends 4 bytes LSB-first and 4 txen slots per byte.
- Captures one word per grant, launches the transmitter, waits for completion, then enforces an inter-word gap.

Parameters:
- NREQ, 4, number of requesters (2..8).
- GAP_CYC, 16'd100, idle clocks between the end of one word and the next launch.
- TMO_CYC, 16'd1000, max clocks from tx_start to tx_busy rising before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-low, one clock domain
- req  in  NREQ  per-requester level request; held until its grant bit pulses
- req_data  in  NREQ*32  requester i word at bits [32*i+31:32*i]
- grant  out  NREQ  one-hot, 1-cycle pulse; the word was captured and the requester may drop req
- tx_start  out  1  1-cycle pulse that launches the transmitter
- tx_word  out  32  captured word; stable from tx_start until the transmitter finishes
- tx_busy  in  1  transmitter is sending
- active  out  1  high in every state except IDLE
- cur_id  out  3  index of the requester being served; holds its last value in IDLE
- err  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset (async, rst=0): grant=0, tx_start=0, tx_word=0, active=0, cur_id=0, err=0, rr_ptr=NREQ-1, gap_cnt=0, state=IDLE.
- State IDLE:
  - When any req bit is high, pick the first set bit searching from rr_ptr+1 upward, modulo NREQ.
  - Same cycle: register tx_word = that requester's data, set grant[i]=1, cur_id=i, rr_ptr=i.
  - Next state: LAUNCH.
- State LAUNCH: tx_start=1 for exactly one cycle, grant back to 0. Load tmo_cnt=0. Next state: WAIT_BUSY.
- State WAIT_BUSY:
  - tx_busy=1 goes to WAIT_DONE.
  - Otherwise increment tmo_cnt. On tmo_cnt==TMO_CYC-1, set err=1 and go to GAP (word dropped, no retry).
- State WAIT_DONE: tx_busy falling goes to GAP with gap_cnt=0.
- State GAP: increment gap_cnt. On gap_cnt==GAP_CYC-1 go to IDLE. GAP_CYC=0 is treated as 1.
- Latency: req high in IDLE gives grant in the same clock-edge update, so grant and tx_word register on the same edge. tx_start follows 1 cycle later.
- Simultaneous requests are served strictly round-robin. One grant per word; no requester is served twice while another is pending.
- A req that drops before being granted is ignored; no partial state is kept.
- A req bit still high after its grant is treated as a new request and re-arbitrated after GAP.
- tx_busy high already in IDLE: arbitration stalls until tx_busy=0.
- Reset mid-word: everything returns to reset values. The transmitter is reset on the same rst.
- Counters are 16-bit unsigned and do not wrap; they are compared with ==.

Optional Feature:
- Macro TXARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. If req[0] is set in IDLE it wins regardless of rr_ptr, and rr_ptr is not updated. Requesters 1..NREQ-1 stay round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters.

Decomposition:
- Shared package txarb_pkg:
  - state enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP}
  - constant WORD_W=32
  - constant BYTE_SLOT_CYC=16'd12432, the per-slot clock count used by the transmitter; used by benches to size TMO_CYC.
- One sub-module: rr_pick, a combinational next-index finder taking req, rr_ptr and the prio option, returning valid and idx.

Test Plan:
- Single request: req=4'b0010, data1=32'hA5A5_1234; tx_busy goes high 3 cycles after tx_start, low 200 cycles later -> grant=4'b0010 for 1 cycle, tx_word=32'hA5A5_1234, next grant no earlier than GAP_CYC cycles after tx_busy falls.
- Fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0. cur_id matches each grant.
- Timeout: tx_busy tied 0, TMO_CYC=10 -> err=1 exactly 10 cycles after the WAIT_BUSY entry; arbiter returns to IDLE after GAP; err stays 1.
- Async reset mid-WAIT_DONE -> all outputs at reset values immediately, without waiting for a clk edge. After release with req=4'b0001, grant goes to index 0.
- Busy stall: tx_busy=1 in IDLE with req=4'b0100 -> no grant until tx_busy=0, then grant=4'b0100.
- With TXARB_PRIO0_EN defined, req=4'b1111 held -> sequence 0,0,0... until req[0] drops, then round-robin among 1,2,3.

Source files
------------

// File: rtl/txarb_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the transmit word arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, word width, transmitter slot timing, gap helper.
package txarb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam int          WORD_W        = 32;
    // Clocks per txen slot in the word transmitter; benches size TMO_CYC from it.
    localparam logic [15:0] BYTE_SLOT_CYC = 16'd12432;

    // A zero-length gap still spends one cycle in GAP.
    function automatic logic [15:0] eff_gap(input logic [15:0] g);
        return (g == 16'd0) ? 16'd1 : g;
    endfunction

endpackage

// File: rtl/tx_word_arbiter_if.sv
`timescale 1ns/1ps
// Bundles requester-side and transmitter-side signals of the word arbiter.
// Latency: n/a (wires only).
// Backpressure: req is a level held until its grant bit pulses; tx_busy stalls the arbiter.
// Ports: req/req_data from requesters, grant back; tx_start/tx_word/tx_busy to the
//        transmitter; active/cur_id/err status. master = arbiter, slave = environment.
interface tx_word_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    grant;
    logic               tx_start;
    logic [31:0]        tx_word;
    logic               tx_busy;
    logic               active;
    logic [2:0]         cur_id;
    logic               err;

    modport master (
        input  req, req_data, tx_busy,
        output grant, tx_start, tx_word, active, cur_id, err
    );

    modport slave (
        output req, req_data, tx_busy,
        input  grant, tx_start, tx_word, active, cur_id, err
    );
endinterface

// File: rtl/tx_word_arbiter_rr_pick.sv
`timescale 1ns/1ps
// Combinational round-robin finder: first set req bit after rr_ptr, modulo NREQ.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; vld_o low when no request is pending.
// Ports: req_i, rr_ptr_i in; vld_o, idx_o, upd_o (write idx back to rr_ptr) out.
// Macro TXARB_PRIO0_EN: requester 0 wins outright and leaves the pointer untouched.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [2:0]      rr_ptr_i,
    output logic            vld_o,
    output logic [2:0]      idx_o,
    output logic            upd_o
);
    always_comb begin
        vld_o = 1'b0;
        idx_o = rr_ptr_i;
        upd_o = 1'b0;
        // Offsets 1..NREQ: the last-served requester is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            if (!vld_o && req_i[(int'(rr_ptr_i) + k) % NREQ]) begin
                vld_o = 1'b1;
                idx_o = 3'((int'(rr_ptr_i) + k) % NREQ);
                upd_o = 1'b1;
            end
        end
`ifdef TXARB_PRIO0_EN
        // Requester 0 bypasses rotation so 1..NREQ-1 keep their own fairness.
        if (req_i[0]) begin
            vld_o = 1'b1;
            idx_o = 3'd0;
            upd_o = 1'b0;
        end
`endif
    end
endmodule

// File: rtl/tx_word_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one byte-serial word transmitter among NREQ requesters.
// Latency: grant and tx_word on the edge that sees req in IDLE; tx_start one cycle later.
// Backpressure: tx_busy high in IDLE stalls arbitration; inter-word gap of GAP_CYC clocks.
// Ports: clk, rst (async active-low), bus (tx_word_arbiter_if.master).
// Macro TXARB_PRIO0_EN: requester 0 gets fixed top priority (see rr_pick).
module tx_word_arbiter
    import txarb_pkg::*;
#(
    parameter int          NREQ    = 4,
    parameter logic [15:0] GAP_CYC = 16'd100,
    parameter logic [15:0] TMO_CYC = 16'd1000
) (
    input  logic                   clk,
    input  logic                   rst,
    tx_word_arbiter_if.master      bus
);
    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              tx_start_q, tx_start_d;
    logic [WORD_W-1:0] tx_word_q, tx_word_d;
    logic [2:0]        cur_id_q, cur_id_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic              err_q, err_d;

    logic              pick_vld;
    logic [2:0]        pick_idx;
    logic              pick_upd;
    logic [WORD_W-1:0] pick_word;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .vld_o    (pick_vld),
        .idx_o    (pick_idx),
        .upd_o    (pick_upd)
    );

    always_comb begin
        pick_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == 3'(i)) pick_word = bus.req_data[WORD_W*i +: WORD_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        tx_start_d = 1'b0;
        tx_word_d  = tx_word_q;
        cur_id_d   = cur_id_q;
        rr_ptr_d   = rr_ptr_q;
        tmo_cnt_d  = tmo_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                // A transmitter still busy from before (e.g. its own reset lag) holds us off.
                if (!bus.tx_busy && pick_vld) begin
                    tx_word_d = pick_word;
                    grant_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    cur_id_d  = pick_idx;
                    if (pick_upd) rr_ptr_d = pick_idx;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_d = 1'b1;
                tmo_cnt_d  = 16'd0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_CYC - 16'd1) begin
                    // Transmitter never answered: drop the word, flag it, keep going.
                    err_d     = 1'b1;
                    gap_cnt_d = 16'd0;
                    state_d   = GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    gap_cnt_d = 16'd0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == eff_gap(GAP_CYC) - 16'd1) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_word_q  <= '0;
            cur_id_q   <= 3'd0;
            rr_ptr_q   <= 3'(NREQ - 1);
            tmo_cnt_q  <= 16'd0;
            gap_cnt_q  <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_word_q  <= tx_word_d;
            cur_id_q   <= cur_id_d;
            rr_ptr_q   <= rr_ptr_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_word  = tx_word_q;
    assign bus.cur_id   = cur_id_q;
    assign bus.err      = err_q;
    assign bus.active   = (state_q != IDLE);

endmodule

// File: tb/tb_tx_word_arbiter.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for tx_word_arbiter with a transmitter model.
// Latency: n/a.
// Backpressure: the transmitter model drives tx_busy with random or fixed timing.
module tb_tx_word_arbiter;
    localparam int          NREQ = 4;
    localparam logic [15:0] GAP  = 16'd8;
    localparam logic [15:0] TMO  = 16'd10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tx_word_arbiter_if #(.NREQ(NREQ)) bus ();

    tx_word_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          hold = 0;
    bit          xmit_en = 1;
    int          dly_fix = 0;
    int          len_fix = 0;
    int          xst = 0;
    int          xcnt = 0;
    int          fall_cyc = -1;
    int          grant_cyc = -1;
    int          grants_seen = 0;
    int          m_last = NREQ - 1;
    logic [31:0] last_data = '0;
    logic [31:0] data_arr[NREQ];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: winner is the first pending requester after the last served one.
    function automatic void pick(input logic [NREQ-1:0] m, input int last,
                                 output int id, output int nlast);
        id = -1;
        nlast = last;
`ifdef TXARB_PRIO0_EN
        if (m[0]) begin
            id = 0;
            return;
        end
`endif
        for (int k = 1; k <= NREQ; k++) begin
            if (id < 0 && m[(last + k) % NREQ]) begin
                id = (last + k) % NREQ;
                nlast = id;
            end
        end
    endfunction

    task automatic drive_req(input logic [NREQ-1:0] m);
        for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = data_arr[i];
        bus.req = m;
    endtask

    // Requests raised together while idle; each dropped at its own grant.
    task automatic issue(input logic [NREQ-1:0] m, input int fix_id, input logic [31:0] fix_d);
        logic [NREQ-1:0] rem;
        int id, nl;
        for (int i = 0; i < NREQ; i++) data_arr[i] = (i == fix_id) ? fix_d : $urandom;
        rem = m;
        while (rem != '0) begin
            pick(rem, m_last, id, nl);
            sb.push_back('{id, data_arr[id]});
            m_last = nl;
            rem[id] = 1'b0;
        end
        drive_req(m);
    endtask

    // Requests held high for n grants, then released.
    task automatic issue_held(input logic [NREQ-1:0] m, input int n);
        int id, nl;
        for (int i = 0; i < NREQ; i++) data_arr[i] = $urandom;
        for (int k = 0; k < n; k++) begin
            pick(m, m_last, id, nl);
            sb.push_back('{id, data_arr[id]});
            m_last = nl;
        end
        hold = 1;
        drive_req(m);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (n < budget && (sb.size() != 0 || bus.active || hold)) begin
            @(negedge clk);
            n++;
            if (hold && sb.size() == 0) begin
                bus.req = '0;
                hold = 0;
            end
        end
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_idle", {31'd0, bus.active}, 0);
    endtask

    // Monitor/scoreboard, then requester drop, then transmitter model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.grant != '0) begin
                    grants_seen++;
                    grant_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk("unexpected_grant", {28'd0, bus.grant}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("grant_onehot", {28'd0, bus.grant}, 32'd1 << e.id);
                        chk("grant_word", bus.tx_word, e.data);
                        chk("grant_cur_id", {29'd0, bus.cur_id}, e.id);
                        last_data = e.data;
                    end
                    if (fall_cyc >= 0) chk("gap_respected", (cyc - fall_cyc) >= int'(GAP), 1);
                    fall_cyc = -1;
                    if (!hold) bus.req = bus.req & ~bus.grant;
                end
                if (bus.tx_start) begin
                    chk("start_latency", cyc - grant_cyc, 1);
                    chk("start_word", bus.tx_word, last_data);
                    chk("start_active", {31'd0, bus.active}, 1);
                end
                if (xst == 0) begin
                    if (bus.tx_start && xmit_en) begin
                        xcnt = (dly_fix != 0) ? dly_fix : $urandom_range(1, 4);
                        xst = 1;
                    end
                end else if (xst == 1) begin
                    xcnt--;
                    if (xcnt == 0) begin
                        bus.tx_busy = 1'b1;
                        xcnt = (len_fix != 0) ? len_fix : $urandom_range(5, 30);
                        xst = 2;
                    end
                end else begin
                    xcnt--;
                    if (xcnt == 0) begin
                        bus.tx_busy = 1'b0;
                        xst = 0;
                        fall_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        int n, g0;
        bus.req = '0;
        bus.req_data = '0;
        bus.tx_busy = 1'b0;

        // Reset values
        #3;
        chk("rst_grant", {28'd0, bus.grant}, 0);
        chk("rst_tx_start", {31'd0, bus.tx_start}, 0);
        chk("rst_tx_word", bus.tx_word, 0);
        chk("rst_active", {31'd0, bus.active}, 0);
        chk("rst_cur_id", {29'd0, bus.cur_id}, 0);
        chk("rst_err", {31'd0, bus.err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single request, fixed transmitter timing
        dly_fix = 3;
        len_fix = 200;
        issue(4'b0010, 1, 32'hA5A5_1234);
        wait_drain(1000);
        dly_fix = 0;
        len_fix = 0;

        // Two pending: second grant must honour the gap
        issue(4'b0110, -1, 32'd0);
        wait_drain(500);

        // Fairness with all requests held
        issue_held(4'b1111, 5);
        wait_drain(1000);

        // Busy stall in IDLE
        xmit_en = 0;
        bus.tx_busy = 1'b1;
        g0 = grants_seen;
        issue(4'b0100, -1, 32'd0);
        repeat (20) @(negedge clk);
        chk("stall_no_grant", grants_seen - g0, 0);
        bus.tx_busy = 1'b0;
        xmit_en = 1;
        wait_drain(500);

        // Random batches
        for (int b = 0; b < 25; b++) begin
            issue(4'($urandom_range(1, 15)), -1, 32'd0);
            wait_drain(1000);
        end

        // Timeout: transmitter never answers
        chk("err_before_tmo", {31'd0, bus.err}, 0);
        xmit_en = 0;
        issue(4'b1000, -1, 32'd0);
        n = 0;
        while (!bus.tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_start_seen", {31'd0, bus.tx_start}, 1);
        n = 0;
        while (!bus.err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", n, 10);
        wait_drain(200);
        chk("err_sticky", {31'd0, bus.err}, 1);
        xmit_en = 1;

        // Async reset while the transmitter is mid-word
        len_fix = 60;
        issue(4'b0100, -1, 32'd0);
        n = 0;
        while (!bus.tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_seen", {31'd0, bus.tx_busy}, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_grant", {28'd0, bus.grant}, 0);
        chk("arst_tx_start", {31'd0, bus.tx_start}, 0);
        chk("arst_tx_word", bus.tx_word, 0);
        chk("arst_active", {31'd0, bus.active}, 0);
        chk("arst_cur_id", {29'd0, bus.cur_id}, 0);
        chk("arst_err", {31'd0, bus.err}, 0);
        sb.delete();
        m_last = NREQ - 1;
        bus.req = '0;
        bus.tx_busy = 1'b0;
        xst = 0;
        len_fix = 0;
        fall_cyc = -1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(4'b0001, -1, 32'd0);
        wait_drain(500);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
